// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Sequential issue stage sitting directly in front of the combinational ALU.
// Requests {OPRN, OP1, OP2} are accepted over a valid/ready handshake into a
// DEPTH-entry FIFO. One entry at a time is driven onto ALU_* (registered), the
// operands are held for SETTLE_CYCLES edges, and ALU_OUT/ALU_ZERO are captured
// into the result registers. The result is offered downstream over a second
// valid/ready handshake. Results leave strictly in request order.
//
// Optional build macro: ALU_ISSUE_STATS_EN adds saturating STAT_ISSUED and
// STAT_ZERO counters. With the macro undefined those ports do not exist.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   REQ_VALID/REQ_READY      request handshake; REQ_READY = !full (registered count)
//   REQ_OPRN/OP1/OP2         request payload
//   ALU_OPRN/OP1/OP2         registered drive to the ALU
//   ALU_OUT/ALU_ZERO         ALU result inputs
//   RES_VALID/RES_READY      result handshake
//   RES_DATA/ZERO/ERR        captured result; ERR flags unsupported opcode
//   BUSY                     FIFO non-empty or FSM not IDLE
//   STAT_ISSUED/STAT_ZERO    (ALU_ISSUE_STATS_EN only) pop / zero-result counters
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | waiting for a FIFO entry; pops the head when count > 0
//   ST_SETTLE | ALU_* held; settle counter runs down, capture at zero
//   ST_HOLD   | result valid downstream; waits for RES_READY

module alu_issue_stage #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [5:0]  REQ_OPRN,
  input  logic [31:0] REQ_OP1,
  input  logic [31:0] REQ_OP2,
  output logic [5:0]  ALU_OPRN,
  output logic [31:0] ALU_OP1,
  output logic [31:0] ALU_OP2,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZERO,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_DATA,
  output logic        RES_ZERO,
  output logic        RES_ERR,
  output logic        BUSY
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] STAT_ISSUED,
  output logic [15:0] STAT_ZERO
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EW = 6 + 32 + 32;
  localparam logic [AW:0]   FULL_CNT   = DEPTH[AW:0];
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // FSM and datapath registers
  state_t        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [5:0]    alu_oprn_q, alu_oprn_d;
  logic [31:0]   alu_op1_q, alu_op1_d;
  logic [31:0]   alu_op2_q, alu_op2_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_zero_q, res_zero_d;
  logic          res_err_q, res_err_d;

  logic push;
  logic pop;
  logic capture;
  logic op_valid;
  logic [EW-1:0] head;

  assign push     = REQ_VALID && (count_q != FULL_CNT);
  assign head     = mem_q[rd_ptr_q];
  assign op_valid = (alu_oprn_q != 6'd0) && (alu_oprn_q <= 6'd9);

  // FSM next-state and datapath
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_oprn_d  = alu_oprn_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;
    capture     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          alu_oprn_d = head[69:64];
          alu_op1_d  = head[63:32];
          alu_op2_d  = head[31:0];
          settle_d   = SETTLE_LD;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          capture     = 1'b1;
          res_valid_d = 1'b1;
          // Unsupported opcodes never look at ALU_OUT, so the result is
          // deterministic regardless of what the ALU drives for them.
          if (op_valid) begin
            res_data_d = ALU_OUT;
            res_zero_d = ALU_ZERO;
            res_err_d  = 1'b0;
          end else begin
            res_data_d = 32'd0;
            res_zero_d = 1'b1;
            res_err_d  = 1'b1;
          end
          state_d = ST_HOLD;
        end else begin
          settle_d = settle_q - CW'(1);
        end
      end
      ST_HOLD: begin
        // Returning to IDLE here means the next pop is one edge later,
        // which gives the SETTLE_CYCLES+2 cadence.
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO next-state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {REQ_OPRN, REQ_OP1, REQ_OP2};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload needs no reset: only entries counted by count_q are read.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      alu_oprn_q  <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      alu_oprn_q  <= alu_oprn_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_zero_q, stat_zero_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_zero_d   = stat_zero_q;
    if (pop && (stat_issued_q != 16'hFFFF)) begin
      stat_issued_d = stat_issued_q + 16'd1;
    end
    // Error captures force RES_ZERO=1 but are not real zero results.
    if (capture && op_valid && ALU_ZERO && (stat_zero_q != 16'hFFFF)) begin
      stat_zero_d = stat_zero_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_issued_q <= '0;
      stat_zero_q   <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_zero_q   <= stat_zero_d;
    end
  end

  assign STAT_ISSUED = stat_issued_q;
  assign STAT_ZERO   = stat_zero_q;
`endif

  assign REQ_READY = (count_q != FULL_CNT);
  assign ALU_OPRN  = alu_oprn_q;
  assign ALU_OP1   = alu_op1_q;
  assign ALU_OP2   = alu_op2_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_ZERO  = res_zero_q;
  assign RES_ERR   = res_err_q;
  assign BUSY      = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU attached.
// ALU opcode map used here: 1 add, 2 sub, 3 mul, 4 srl, 5 sll, 6 and, 7 or,
// 8 nor, 9 slt; anything else drives a junk value that the stage must ignore.

module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [5:0]  REQ_OPRN;
  logic [31:0] REQ_OP1;
  logic [31:0] REQ_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OP1;
  logic [31:0] ALU_OP2;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic        RES_VALID;
  logic        RES_READY;
  logic [31:0] RES_DATA;
  logic        RES_ZERO;
  logic        RES_ERR;
  logic        BUSY;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] STAT_ISSUED;
  logic [15:0] STAT_ZERO;
`endif

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  bit drop_on_accept = 1'b1;

  logic [5:0]  f_op [5] = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd1};
  logic [31:0] f_a  [5] = '{32'd15, 32'd15, 32'd8, 32'd9, 32'd100};
  logic [31:0] f_b  [5] = '{32'd3, 32'd2, 32'd3, 32'd2, 32'd1};

  always #5 CLK = ~CLK;

  alu_issue_stage #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OPRN  (REQ_OPRN),
    .REQ_OP1   (REQ_OP1),
    .REQ_OP2   (REQ_OP2),
    .ALU_OPRN  (ALU_OPRN),
    .ALU_OP1   (ALU_OP1),
    .ALU_OP2   (ALU_OP2),
    .ALU_OUT   (ALU_OUT),
    .ALU_ZERO  (ALU_ZERO),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_DATA  (RES_DATA),
    .RES_ZERO  (RES_ZERO),
    .RES_ERR   (RES_ERR),
    .BUSY      (BUSY)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .STAT_ISSUED (STAT_ISSUED),
    .STAT_ZERO   (STAT_ZERO)
`endif
  );

  always_comb begin
    case (ALU_OPRN)
      6'd1:    ALU_OUT = ALU_OP1 + ALU_OP2;
      6'd2:    ALU_OUT = ALU_OP1 - ALU_OP2;
      6'd3:    ALU_OUT = ALU_OP1 * ALU_OP2;
      6'd4:    ALU_OUT = ALU_OP1 >> ALU_OP2;
      6'd5:    ALU_OUT = ALU_OP1 << ALU_OP2;
      6'd6:    ALU_OUT = ALU_OP1 & ALU_OP2;
      6'd7:    ALU_OUT = ALU_OP1 | ALU_OP2;
      6'd8:    ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'd9:    ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = 32'hDEADBEEF;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the following falling edge.
  task automatic step();
    bit acc;
    acc = REQ_VALID && REQ_READY;
    @(posedge CLK);
    @(negedge CLK);
    if (acc) begin
      accepts++;
      if (drop_on_accept) REQ_VALID = 1'b0;
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    REQ_VALID = 1'b1;
    REQ_OPRN  = op;
    REQ_OP1   = a;
    REQ_OP2   = b;
    step();
    REQ_VALID = 1'b0;
  endtask

  // Waits (bounded) for a result, checks it, then spends one edge so a
  // ready consumer takes it.
  task automatic wait_res(input string tag, input logic [31:0] d, input logic z, input logic e);
    int n;
    n = 0;
    while (RES_VALID !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(RES_VALID), 32'd1);
    chk({tag, "_data"},  RES_DATA, d);
    chk({tag, "_zero"},  32'(RES_ZERO), 32'(z));
    chk({tag, "_err"},   32'(RES_ERR), 32'(e));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_OPRN  = '0;
    REQ_OP1   = '0;
    REQ_OP2   = '0;
    RES_READY = 1'b0;
    @(negedge CLK);
    step();
    step();
    RST = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_res_valid", 32'(RES_VALID), 32'd0);
    chk("rst_busy",      32'(BUSY), 32'd0);
    chk("rst_alu_op1",   ALU_OP1, 32'd0);
    chk("rst_res_data",  RES_DATA, 32'd0);

    // Single add, exact latency: valid after accept edge + 2
    RES_READY = 1'b1;
    push(6'd1, 32'd15, 32'd3);
    chk("add_lat_e0", 32'(RES_VALID), 32'd0);
    chk("add_busy",   32'(BUSY), 32'd1);
    step();
    chk("add_lat_e1", 32'(RES_VALID), 32'd0);
    chk("add_alu_op1", ALU_OP1, 32'd15);
    step();
    chk("add_lat_e2", 32'(RES_VALID), 32'd1);
    chk("add_data",   RES_DATA, 32'd18);
    chk("add_zero",   32'(RES_ZERO), 32'd0);
    chk("add_err",    32'(RES_ERR), 32'd0);
    step();
    chk("add_release", 32'(RES_VALID), 32'd0);
    chk("add_idle",    32'(BUSY), 32'd0);
    chk("alu_retain",  ALU_OP1, 32'd15);

    // Back-to-back subtracts, in order
    REQ_VALID = 1'b1; REQ_OPRN = 6'd2; REQ_OP1 = 32'd5;  REQ_OP2 = 32'd5;
    step();
    REQ_VALID = 1'b1; REQ_OPRN = 6'd2; REQ_OP1 = 32'd12; REQ_OP2 = 32'd5;
    step();
    REQ_VALID = 1'b0;
    wait_res("sub0", 32'd0, 1'b1, 1'b0);
    wait_res("sub7", 32'd7, 1'b0, 1'b0);

    // Fill: park a result in HOLD, then offer 5 requests; only 4 fit
    RES_READY = 1'b0;
    push(6'd1, 32'd1, 32'd1);
    wait_res("hold", 32'd2, 1'b0, 1'b0);
    accepts = 0;
    drop_on_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      REQ_VALID = 1'b1;
      REQ_OPRN  = f_op[i];
      REQ_OP1   = f_a[i];
      REQ_OP2   = f_b[i];
      chk("fill_ready", 32'(REQ_READY), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("fill_accepts", 32'(accepts), 32'd4);
    chk("full_ready",   32'(REQ_READY), 32'd0);
    drop_on_accept = 1'b1;
    RES_READY = 1'b1;
    wait_res("drain_hold", 32'd2,  1'b0, 1'b0);
    wait_res("drain_add",  32'd18, 1'b0, 1'b0);
    wait_res("drain_mul",  32'd30, 1'b0, 1'b0);
    wait_res("drain_srl",  32'd1,  1'b0, 1'b0);
    wait_res("drain_sll",  32'd36, 1'b0, 1'b0);
    wait_res("drain_5th",  32'd101, 1'b0, 1'b0);
    chk("fifth_accepted", 32'(accepts), 32'd5);

    // Unsupported opcode: same latency, forced result
    push(6'd10, 32'd1, 32'd1);
    chk("err_lat_e0", 32'(RES_VALID), 32'd0);
    step();
    chk("err_lat_e1", 32'(RES_VALID), 32'd0);
    step();
    chk("err_lat_e2", 32'(RES_VALID), 32'd1);
    chk("err_data",   RES_DATA, 32'd0);
    chk("err_zero",   32'(RES_ZERO), 32'd1);
    chk("err_err",    32'(RES_ERR), 32'd1);
    step();
    chk("err_release", 32'(RES_VALID), 32'd0);

    // Reset while in SETTLE with two entries still queued
    RES_READY = 1'b0;
    push(6'd1, 32'd40, 32'd2);
    wait_res("pre_rst", 32'd42, 1'b0, 1'b0);
    push(6'd1, 32'd50, 32'd1);
    push(6'd1, 32'd60, 32'd1);
    push(6'd1, 32'd70, 32'd1);
    RES_READY = 1'b1;
    step();
    step();
    chk("settle_op1",   ALU_OP1, 32'd50);
    chk("settle_valid", 32'(RES_VALID), 32'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_valid", 32'(RES_VALID), 32'd0);
    chk("mid_rst_busy",  32'(BUSY), 32'd0);
    chk("mid_rst_ready", 32'(REQ_READY), 32'd1);
    chk("mid_rst_op1",   ALU_OP1, 32'd0);
    chk("mid_rst_oprn",  32'(ALU_OPRN), 32'd0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0) stale++;
      step();
    end
    chk("no_stale", 32'(stale), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    chk("stat_rst_issued", 32'(STAT_ISSUED), 32'd0);
    push(6'd2, 32'd5, 32'd5);
    wait_res("st_sub", 32'd0, 1'b1, 1'b0);
    push(6'd1, 32'd1, 32'd1);
    wait_res("st_add", 32'd2, 1'b0, 1'b0);
    push(6'd10, 32'd0, 32'd0);
    wait_res("st_err", 32'd0, 1'b1, 1'b1);
    chk("stat_issued", 32'(STAT_ISSUED), 32'd3);
    chk("stat_zero",   32'(STAT_ZERO), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Sequential stage directly upstream of the combinational ALU. It accepts operation requests (OPRN, OP1, OP2) over a valid/ready handshake into a small FIFO. It drives them to the ALU one at a time, holds the operands stable for a settle window, then captures OUT/ZERO. The captured result is presented downstream over a second valid/ready handshake. Standardised ALU access point for the control unit and the ALU benches.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
SETTLE_CYCLES, 1, clock edges ALU inputs are held before capture (>=1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  1  request present
REQ_READY  output  1  FIFO can accept (= !full, from registered count)
REQ_OPRN  input  6  ALU operation code
REQ_OP1  input  32  operand 1
REQ_OP2  input  32  operand 2
ALU_OPRN  output  6  registered drive to ALU OPRN
ALU_OP1  output  32  registered drive to ALU OP1
ALU_OP2  output  32  registered drive to ALU OP2
ALU_OUT  input  32  ALU result
ALU_ZERO  input  1  ALU zero flag
RES_VALID  output  1  captured result present
RES_READY  input  1  consumer accepts result
RES_DATA  output  32  captured result
RES_ZERO  output  1  captured zero flag
RES_ERR  output  1  request had an unsupported opcode
BUSY  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (RST=1 at an edge): FIFO emptied (count=0, pointers=0), FSM->IDLE, settle counter 0. All outputs 0 except REQ_READY=1. Any in-flight operation and undelivered result are dropped. RST applies on any cycle, including mid-SETTLE and HOLD.
- Push: at an edge with REQ_VALID & REQ_READY, {OPRN,OP1,OP2} is written at the write pointer. Pointers wrap modulo DEPTH.
- Full (count==DEPTH): REQ_READY=0. A push is refused even when a pop occurs in the same cycle. Push and pop in the same cycle when not full: count unchanged, both take effect.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: if count>0 at an edge, pop the head into ALU_OPRN/ALU_OP1/ALU_OP2 and load the settle counter with SETTLE_CYCLES-1 -> SETTLE. An entry pushed at edge E is poppable no earlier than E+1.
- SETTLE: ALU_* held constant. At an edge with counter==0, capture into the result registers and set RES_VALID=1 -> HOLD. Otherwise decrement the counter.
- Capture for valid opcode (1..9): RES_DATA=ALU_OUT, RES_ZERO=ALU_ZERO, RES_ERR=0.
- Capture for opcode 0 or >9: RES_DATA=0, RES_ZERO=1, RES_ERR=1. ALU_OUT is ignored. Latency is identical to a valid opcode.
- HOLD: RES_DATA/RES_ZERO/RES_ERR stable while RES_VALID=1. At an edge with RES_READY=1, RES_VALID->0 -> IDLE. No new pop happens in that same edge.
- Latency: accept edge E -> RES_VALID high after edge E+1+SETTLE_CYCLES (back-to-back minimum). Throughput is one result per SETTLE_CYCLES+2 cycles with RES_READY held high.
- ALU_* outputs retain their last values in IDLE/HOLD and change only on a pop or reset.
- Results are delivered strictly in request order.
- BUSY = (count!=0) | (state!=IDLE).

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs STAT_ISSUED[15:0] and STAT_ZERO[15:0], both reset to 0.
  - STAT_ISSUED increments on each pop.
  - STAT_ZERO increments on each capture with RES_ZERO=1 and RES_ERR=0.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push {0x01,15,3} with RES_READY=1, SETTLE_CYCLES=1, ALU attached -> RES_VALID exactly 2 edges after accept; RES_DATA=18, RES_ZERO=0, RES_ERR=0.
- Push {0x02,5,5} then {0x02,12,5} back-to-back -> in-order results 0 (RES_ZERO=1), then 7 (RES_ZERO=0).
- RES_READY=0, push 5 requests on consecutive cycles -> 4 accepted, REQ_READY=0 after the 4th. Raise RES_READY -> results in order: 15+3=18, 15*2=30, 8>>3=1, 9<<2=36; 5th request re-presented and accepted once not full.
- Push {0x0A,1,1} -> RES_ERR=1, RES_DATA=0, RES_ZERO=1, same latency as a valid op.
- Assert RST during SETTLE with 2 queued requests -> next edge: RES_VALID=0, BUSY=0, REQ_READY=1, ALU_*=0; no stale result ever emitted.
- With ALU_ISSUE_STATS_EN: issue {0x02,5,5}, {0x01,1,1}, {0x0A,0,0} -> STAT_ISSUED=3, STAT_ZERO=1.
